// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for the MEM-stage data RAM controller.
// The CPU holds the master modport and the unit holds the slave modport.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic [2:0]        op;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, op, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, op, addr, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store engine for a word-only data RAM. Sub-word stores are done
// as read-modify-write. All RAM-side and CPU-side outputs are registered.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  cpu,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wtData,
  input  logic [DATA_W-1:0] ram_rdData
);

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpSw  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;
  localparam logic [2:0] OpSb  = 3'b110;
  localparam logic [2:0] OpSh  = 3'b111;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e              state_q;
  logic [2:0]          op_q;
  logic [1:0]          off_q;
  logic [15:0]         wdata_q;
  logic                busy_q, done_q, err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ram_ce_q, ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wt_q;
  logic                acc_err;

  // Big-endian lanes: byte offset 0 is bits [31:24].
  function automatic logic [31:0] load_ext(logic [2:0] op, logic [1:0] off, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'h0, b};
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [2:0] op, logic [1:0] off, logic [15:0] wd,
                                        logic [31:0] w);
    logic [31:0] m;
    m = w;
    if (op == OpSh) begin
      if (off[1]) m[15:0] = wd;
      else        m[31:16] = wd;
    end else begin
      unique case (off)
        2'd0:    m[31:24] = wd[7:0];
        2'd1:    m[23:16] = wd[7:0];
        2'd2:    m[15:8]  = wd[7:0];
        default: m[7:0]   = wd[7:0];
      endcase
    end
    return m;
  endfunction

  always_comb begin
    acc_err = 1'b0;
    if ((cpu.op == OpLh || cpu.op == OpLhu || cpu.op == OpSh) && cpu.addr[0]) acc_err = 1'b1;
    if ((cpu.op == OpLw || cpu.op == OpSw) && (cpu.addr[1:0] != 2'b00))       acc_err = 1'b1;
    if (cpu.addr[31:ADDR_W] != '0)                                            acc_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_wt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          if (cpu.req) begin
            busy_q <= 1'b1;
            if (acc_err) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              op_q       <= cpu.op;
              off_q      <= cpu.addr[1:0];
              wdata_q    <= cpu.wdata[15:0];
              ram_addr_q <= {cpu.addr[ADDR_W-1:2], 2'b00};
              ram_ce_q   <= 1'b1;
              if (cpu.op == OpSw) begin
                state_q  <= StWr;
                ram_we_q <= 1'b1;
                ram_wt_q <= cpu.wdata;
              end else begin
                state_q <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (op_q == OpSb || op_q == OpSh) begin
            state_q  <= StWr;
            ram_we_q <= 1'b1;
            ram_wt_q <= merge(op_q, off_q, wdata_q, ram_rdData);
          end else begin
            state_q  <= StDone;
            ram_ce_q <= 1'b0;
            rdata_q  <= load_ext(op_q, off_q, ram_rdData);
            done_q   <= 1'b1;
          end
        end
        StWr: begin
          state_q  <= StDone;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          done_q   <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu.busy   = busy_q;
  assign cpu.done   = done_q;
  assign cpu.err    = err_q;
  assign cpu.rdata  = rdata_q;
  assign ram_ce     = ram_ce_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wtData = ram_wt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single accesses run
// against a behavioural word RAM, then hand-written reset/busy/back-to-back cases.
module tb_mem_access_unit;

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpSw  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;
  localparam logic [2:0] OpSb  = 3'b110;
  localparam logic [2:0] OpSh  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ce, ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wtData, ram_rdData;

  mem_access_unit_if #(.DATA_W(32)) cpu_if ();

  mem_access_unit #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wtData (ram_wtData),
    .ram_rdData (ram_rdData)
  );

  always #5 clk = ~clk;

  // Behavioural RAM plus activity counters.
  logic [31:0] mem [512];
  int          ce_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [10:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  // Non-read cycles return a junk pattern so stray sampling shows up.
  assign ram_rdData = (ram_ce && !ram_we) ? mem[ram_addr[10:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (ram_ce) ce_cnt <= ce_cnt + 1;
    if (cpu_if.done) done_cnt <= done_cnt + 1;
    if (ram_ce && ram_we) begin
      mem[ram_addr[10:2]] <= ram_wtData;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= ram_addr;
      wr_data <= ram_wtData;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    int          ce;
    int          wr;
    logic [31:0] wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata, logic err,
                             int lat, logic [31:0] rdata, int ce, int wr, logic [31:0] wa,
                             logic [31:0] wd);
    vec_t r;
    r.op = op; r.addr = addr; r.wdata = wdata; r.err = err; r.lat = lat;
    r.rdata = rdata; r.ce = ce; r.wr = wr; r.wa = wa; r.wd = wd;
    return r;
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 20 && cpu_if.busy; k++) @(negedge clk);
  endtask

  // Issue one request; lat counts negedges from the sampling edge until done (0 = timeout).
  task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic e, output logic [31:0] rd);
    lat = 0;
    e   = 1'b0;
    rd  = '0;
    wait_idle();
    cpu_if.req   = 1'b1;
    cpu_if.op    = op;
    cpu_if.addr  = addr;
    cpu_if.wdata = wdata;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cpu_if.req = 1'b0;
      if (cpu_if.done) begin
        lat = k;
        e   = cpu_if.err;
        rd  = cpu_if.rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ce0, wr0, d0;
    logic        e;
    logic [31:0] rd;

    vecs.push_back(v(OpSw,  32'h10,  32'hDEADBEEF, 0, 2, 32'h0,        1, 1, 32'h10, 32'hDEADBEEF));
    vecs.push_back(v(OpLw,  32'h10,  32'h0,        0, 2, 32'hDEADBEEF, 1, 0, 0, 0));
    vecs.push_back(v(OpSw,  32'h20,  32'h11223344, 0, 2, 32'hDEADBEEF, 1, 1, 32'h20, 32'h11223344));
    vecs.push_back(v(OpSb,  32'h21,  32'h000000AB, 0, 3, 32'hDEADBEEF, 2, 1, 32'h20, 32'h11AB3344));
    vecs.push_back(v(OpLw,  32'h20,  32'h0,        0, 2, 32'h11AB3344, 1, 0, 0, 0));
    vecs.push_back(v(OpSw,  32'h30,  32'h80FF7F01, 0, 2, 32'h11AB3344, 1, 1, 32'h30, 32'h80FF7F01));
    vecs.push_back(v(OpLb,  32'h30,  32'h0,        0, 2, 32'hFFFFFF80, 1, 0, 0, 0));
    vecs.push_back(v(OpLbu, 32'h30,  32'h0,        0, 2, 32'h00000080, 1, 0, 0, 0));
    vecs.push_back(v(OpLh,  32'h32,  32'h0,        0, 2, 32'h00007F01, 1, 0, 0, 0));
    vecs.push_back(v(OpLhu, 32'h30,  32'h0,        0, 2, 32'h000080FF, 1, 0, 0, 0));
    vecs.push_back(v(OpLb,  32'h33,  32'h0,        0, 2, 32'h00000001, 1, 0, 0, 0));
    vecs.push_back(v(OpLb,  32'h31,  32'h0,        0, 2, 32'hFFFFFFFF, 1, 0, 0, 0));
    vecs.push_back(v(OpLh,  32'h30,  32'h0,        0, 2, 32'hFFFF80FF, 1, 0, 0, 0));
    vecs.push_back(v(OpLw,  32'h22,  32'h0,        1, 1, 32'hFFFF80FF, 0, 0, 0, 0));
    vecs.push_back(v(OpSh,  32'h23,  32'h1234,     1, 1, 32'hFFFF80FF, 0, 0, 0, 0));
    vecs.push_back(v(OpSw,  32'h800, 32'h1234,     1, 1, 32'hFFFF80FF, 0, 0, 0, 0));
    vecs.push_back(v(OpLhu, 32'h21,  32'h0,        1, 1, 32'hFFFF80FF, 0, 0, 0, 0));
    vecs.push_back(v(OpLw,  32'h80000010, 32'h0,   1, 1, 32'hFFFF80FF, 0, 0, 0, 0));
    vecs.push_back(v(OpSh,  32'h22,  32'h1234CAFE, 0, 3, 32'hFFFF80FF, 2, 1, 32'h20, 32'h11ABCAFE));
    vecs.push_back(v(OpSb,  32'h33,  32'h00000055, 0, 3, 32'hFFFF80FF, 2, 1, 32'h30, 32'h80FF7F55));
    vecs.push_back(v(OpLw,  32'h30,  32'h0,        0, 2, 32'h80FF7F55, 1, 0, 0, 0));
    vecs.push_back(v(OpSw,  32'h7FC, 32'h5A5A0000, 0, 2, 32'h80FF7F55, 1, 1, 32'h7FC, 32'h5A5A0000));
    vecs.push_back(v(OpLbu, 32'h7FD, 32'h0,        0, 2, 32'h0000005A, 1, 0, 0, 0));
    vecs.push_back(v(OpLh,  32'h7FC, 32'h0,        0, 2, 32'h00005A5A, 1, 0, 0, 0));
    vecs.push_back(v(OpSb,  32'h20,  32'hFFFFFF00, 0, 3, 32'h00005A5A, 2, 1, 32'h20, 32'h00ABCAFE));
    vecs.push_back(v(OpLw,  32'h20,  32'h0,        0, 2, 32'h00ABCAFE, 1, 0, 0, 0));

    rst = 1'b1;
    cpu_if.req = 1'b0; cpu_if.op = 3'b000; cpu_if.addr = '0; cpu_if.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'b0, cpu_if.busy}, 32'h0);
    chk("rst_done",  {31'b0, cpu_if.done}, 32'h0);
    chk("rst_err",   {31'b0, cpu_if.err},  32'h0);
    chk("rst_rdata", cpu_if.rdata,         32'h0);
    chk("rst_ce",    {31'b0, ram_ce},      32'h0);
    chk("rst_we",    {31'b0, ram_we},      32'h0);
    chk("rst_addr",  {21'b0, ram_addr},    32'h0);
    chk("rst_wt",    ram_wtData,           32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      ce0 = ce_cnt;
      wr0 = wr_cnt;
      access(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, e, rd);
      chk($sformatf("v%0d_lat", i),   lat,            vecs[i].lat);
      chk($sformatf("v%0d_err", i),   {31'b0, e},     {31'b0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i), rd,             vecs[i].rdata);
      chk($sformatf("v%0d_ce", i),    ce_cnt - ce0,   vecs[i].ce);
      chk($sformatf("v%0d_wr", i),    wr_cnt - wr0,   vecs[i].wr);
      if (vecs[i].wr != 0) begin
        chk($sformatf("v%0d_waddr", i), {21'b0, wr_addr}, vecs[i].wa);
        chk($sformatf("v%0d_wdata", i), wr_data,          vecs[i].wd);
      end
    end

    // Reset during the read phase of an sb: access abandoned, RAM untouched.
    wait_idle();
    wr0 = wr_cnt;
    d0  = done_cnt;
    cpu_if.req = 1'b1; cpu_if.op = OpSb; cpu_if.addr = 32'h10; cpu_if.wdata = 32'h77;
    @(negedge clk);
    cpu_if.req = 1'b0;
    chk("rmw_rd_ce", {31'b0, ram_ce}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy",  {31'b0, cpu_if.busy}, 32'h0);
    chk("mid_done",  {31'b0, cpu_if.done}, 32'h0);
    chk("mid_err",   {31'b0, cpu_if.err},  32'h0);
    chk("mid_rdata", cpu_if.rdata,         32'h0);
    chk("mid_ce",    {31'b0, ram_ce},      32'h0);
    chk("mid_we",    {31'b0, ram_we},      32'h0);
    chk("mid_addr",  {21'b0, ram_addr},    32'h0);
    chk("mid_wt",    ram_wtData,           32'h0);
    repeat (5) @(negedge clk);
    chk("mid_no_done",  done_cnt - d0, 0);
    chk("mid_no_write", wr_cnt - wr0,  0);
    access(OpLw, 32'h10, 32'h0, lat, e, rd);
    chk("mid_word_kept", rd, 32'hDEADBEEF);

    // req pulsed during the WR of an sw is ignored.
    wait_idle();
    d0  = done_cnt;
    ce0 = ce_cnt;
    cpu_if.req = 1'b1; cpu_if.op = OpSw; cpu_if.addr = 32'h40; cpu_if.wdata = 32'h12345678;
    @(negedge clk);
    chk("busy_wr_we", {31'b0, ram_we}, 32'h1);
    cpu_if.op = OpLw; cpu_if.addr = 32'h20;
    @(negedge clk);
    cpu_if.req = 1'b0;
    chk("busy_done", {31'b0, cpu_if.done}, 32'h1);
    repeat (5) @(negedge clk);
    chk("busy_one_done", done_cnt - d0,  1);
    chk("busy_one_ce",   ce_cnt - ce0,   1);
    chk("busy_rdata",    cpu_if.rdata,   32'hDEADBEEF);

    // Back-to-back: req held from DONE through the following IDLE cycle.
    wait_idle();
    cpu_if.req = 1'b1; cpu_if.op = OpLw; cpu_if.addr = 32'h30;
    @(negedge clk);
    cpu_if.req = 1'b0;
    @(negedge clk);
    chk("b2b_done1",  {31'b0, cpu_if.done}, 32'h1);
    chk("b2b_rdata1", cpu_if.rdata,         32'h80FF7F55);
    cpu_if.req = 1'b1; cpu_if.op = OpLw; cpu_if.addr = 32'h40;
    @(negedge clk);
    chk("b2b_idle", {31'b0, cpu_if.busy}, 32'h0);
    @(negedge clk);
    cpu_if.req = 1'b0;
    chk("b2b_rd", {31'b0, cpu_if.done}, 32'h0);
    @(negedge clk);
    chk("b2b_done2",  {31'b0, cpu_if.done}, 32'h1);
    chk("b2b_rdata2", cpu_if.rdata,         32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator/controller that drives the word-wide data RAM on behalf of the CPU MEM stage.
- Translates MIPS loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into RAM chip-select, write-enable, address and data cycles.
- Byte and halfword stores are done as read-modify-write, because the RAM only writes full words.
- Loads are sign- or zero-extended. Misaligned and out-of-range accesses are rejected.

Parameters:
- ADDR_W, 11, RAM byte-address width; [2^ADDR_W-1:0] is the valid space, including the IO-mapped upper half.
- DATA_W, 32, word width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  1  access request; sampled only in IDLE.
- op  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, 110 sb, 111 sh, 011 sw.
- addr  input  32  byte address.
- wdata  input  32  store data; the byte/halfword is taken from the low bits.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  pulses with done when an access was rejected.
- rdata  output  32  extended load result; valid when done=1 and held until the next done.
- ram_ce  output  1  RAM chip select.
- ram_we  output  1  RAM write enable (1 = write).
- ram_addr  output  ADDR_W  word-aligned RAM address, low two bits forced to 00.
- ram_wtData  output  32  RAM write data.
- ram_rdData  input  32  RAM read data; combinational from the RAM, high-Z when not reading.

Behaviour:
- Reset (synchronous, on a clk edge with rst=1):
  - state=IDLE; busy=0, done=0, err=0, rdata=0.
  - ram_ce=0, ram_we=0, ram_addr=0, ram_wtData=0.
  - rst has priority over everything.
  - Reset mid-operation abandons the access: no write is issued after the reset edge and no done is produced.
  - A write already clocked into the RAM before the reset edge is not undone.
- States: IDLE, RD, WR, DONE.
  - IDLE: ram_ce=0, ram_we=0. When req=1, latch op, addr and wdata, then check the access:
    - lh/lhu/sh with addr[0]=1 -> error.
    - lw/sw with addr[1:0]!=0 -> error.
    - addr[31:ADDR_W] != 0 -> error.
    - Error path: go to DONE with err set and no RAM cycle.
    - Otherwise: sw -> WR; any load, sb or sh -> RD.
  - RD: ram_ce=1, ram_we=0, ram_addr = {addr[ADDR_W-1:2],2'b00}. ram_rdData is captured at the end of the cycle.
    - Load: extract and extend, then go to DONE.
    - sb/sh: merge store data into the captured word, then go to WR.
  - WR: ram_ce=1, ram_we=1, ram_addr as above. For sw, ram_wtData=wdata; for sb/sh, the merged word. Next state is DONE.
  - DONE: done=1 for exactly one cycle; err=1 if the access was rejected. ram_ce=0, then return to IDLE.
- Byte lanes are big-endian:
  - Byte offset 0 -> bits[31:24], offset 3 -> bits[7:0].
  - Halfword offset 0 -> [31:16], offset 2 -> [15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Merge replaces only the addressed lane; the other lanes keep their read value.
- Latency from the req-sampling edge to the done cycle:
  - load: 2 cycles; sw: 2; sb/sh: 3; rejected access: 1.
- req is ignored while busy=1; there is no queuing. Back-to-back requests are possible, because req is sampled in the cycle after DONE.
- ram_rdData is never sampled when ram_ce=0 (the bus is high-Z). rdata is unchanged by stores and by rejected accesses.
- RAM outputs are registered, so there are no combinational paths from req/addr to ram_*.

Test Plan:
- sw then lw: sw addr=0x10 wdata=0xDEADBEEF -> one WR cycle with ram_addr=0x10; then lw 0x10 -> rdata=0xDEADBEEF, done 2 cycles after req.
- sb RMW: word 0x11223344 at 0x20, sb addr=0x21 wdata=0xAB -> RD then WR with ram_wtData=0x11AB3344; done 3 cycles after req.
- Load extension on word 0x80FF7F01 at 0x30:
  - lb 0x30 -> 0xFFFFFF80; lbu 0x30 -> 0x00000080.
  - lh 0x32 -> 0x00007F01; lhu 0x30 -> 0x000080FF.
- Misaligned/out-of-range:
  - lw 0x22 -> err=1, done 1 cycle after req, ram_ce never high.
  - sh 0x23 -> same response.
  - sw 0x800 -> same response.
- Reset mid-RMW: assert rst during RD of an sb -> next cycle IDLE with all outputs 0; the RAM word is unchanged; no done.
- req while busy: pulse req with lw during the WR of an sw -> ignored; exactly one done.
